pio_sm_sequencer: RTL and testbench
===================================

Name: pio_sm_sequencer

Overview:
- Per-state-machine instruction sequencer for the openPIO core.
- Owns the program counter, the clock-divider tick, stall handling, delay countdown, wrap and forced (EXEC) instructions.
- Feeds the selected opcode to the instruction decoder and consumes its delay/side-set fields.
- Hands each instruction to the execution unit and registers side-set pin updates.

Parameters:
- ADDR_W, 5, instruction memory address width (32 slots).
- DIV_W, 16, integer clock-divider width.

Ports:
- in_clk  input  1  system clock
- in_rst_n  input  1  asynchronous active-low reset
- in_enable  input  1  state machine enable; low freezes all sequencing state
- in_restart  input  1  synchronous pulse; clears delay, stall, divider and pending force
- in_smClkDiv  input  32  [31:16] integer divider; 0 means 65536
- in_smExecCtrl  input  32  [16:12] wrap_top, [11:7] wrap_bottom
- out_imemAddr  output  5  instruction memory read address (= PC)
- in_imemData  input  16  instruction memory data, combinational read of out_imemAddr
- out_opCode  output  16  opcode to the decoder
- in_delay  input  5  decoded delay for out_opCode
- in_sideEnable  input  1  decoded side-set enable
- in_sideSet  input  5  decoded side-set value
- in_forceValid  input  1  one-cycle pulse; forced instruction request
- in_forceOpcode  input  16  forced opcode, sampled with in_forceValid
- out_execValid  output  1  execution strobe for out_opCode (this cycle)
- in_execStall  input  1  execution unit cannot complete; same-cycle response to out_execValid
- in_jumpValid  input  1  execution unit requests PC load; qualified by out_execValid and !in_execStall
- in_jumpAddr  input  5  jump target
- out_sideSetValid  output  1  registered pulse: apply out_sideSet to pins
- out_sideSet  output  5  registered side-set value
- out_stalled  output  1  registered; high while in STALL state

Behaviour:
- Reset values: PC=0; state RUN; divider count=0; delay count=0; force pending=0; out_sideSet=0; out_sideSetValid=0; out_stalled=0.
- Clock divider:
  - Counter counts only while in_enable=1.
  - tick=1 in the cycle where count==div-1 (div=0 is treated as 65536); the counter then returns to 0.
  - div=1 gives tick every enabled cycle. The first tick after enable or restart comes div cycles later.
  - in_enable=0 holds the counter; in_restart clears it.
- Opcode select: out_opCode = force pending ? force register : in_imemData. out_imemAddr = PC.
- Force capture:
  - in_forceValid sets pending and loads the force register.
  - A second pulse while pending overwrites the register (last wins).
  - Pending clears on the tick that accepts the forced instruction without stall.
- States:
  - RUN: out_execValid = tick & in_enable. On that cycle:
    - in_execStall=1 -> STALL; PC held; delay not loaded.
    - Otherwise: PC update; if in_delay!=0 -> DELAY with count=in_delay, else stay RUN.
  - STALL: out_execValid = tick & in_enable, with the same opcode re-presented. Leaves on the first non-stalled tick, with the same transitions as RUN.
  - DELAY: out_execValid=0. Each tick decrements count; the tick with count==1 returns to RUN.
  - An instruction with delay d and no stall therefore spans 1+d ticks.
- PC update, applied only on an accepted (non-stalled) exec:
  - in_jumpValid -> in_jumpAddr.
  - Forced instruction without jump -> PC unchanged.
  - PC==wrap_top -> wrap_bottom.
  - Otherwise PC+1 modulo 32 (31 -> 0 when wrap_top!=31).
- Side-set:
  - On any exec strobe where in_sideEnable=1 (including the first stalled strobe only), out_sideSetValid pulses high the next cycle and out_sideSet<=in_sideSet.
  - Repeated stall strobes do not re-pulse.
  - Otherwise out_sideSetValid=0 and out_sideSet holds.
- Simultaneous events:
  - in_restart has priority over the tick in the same cycle.
  - in_forceValid in the same cycle as an exec strobe takes effect from the next tick.
- in_enable=0 mid-delay or mid-stall: state, count and PC are frozen and resume unchanged.
- in_restart: state->RUN, delay=0, pending=0, divider=0, PC unchanged.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
- div=1, imem 0..3 no delay, wrap_top=3, wrap_bottom=1 -> PC sequence 0,1,2,3,1,2,3,1; out_execValid every cycle.
- div=3, opcode with in_delay=2 at PC=0 -> execValid at ticks at cycles 3, then next at cycle 12; PC=1 after the first strobe.
- in_execStall high for 2 strobes with in_sideEnable=1, in_sideSet=5'h0A -> one out_sideSetValid pulse with value 0x0A; PC advances only on the 3rd strobe; out_stalled high for the 2 intervening tick periods.
- in_forceValid with 16'hE001 while in DELAY at PC=4 -> forced opcode executes on the first RUN tick; PC remains 4; next strobe presents imem[4].
- in_jumpValid=1 with in_jumpAddr=17 at PC=3=wrap_top -> PC=17 (jump beats wrap).
- in_enable=0 during DELAY count=3 for 10 cycles, then in_restart -> no strobes while disabled; after restart, strobe on the next tick with PC unchanged; async reset -> PC=0, outputs 0.

Source files
------------

// File: rtl/pio_sm_sequencer_if.sv
// Signal bundle between one PIO state-machine sequencer and its control registers,
// instruction memory, decoder and execution unit.
interface pio_sm_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              in_enable;
    logic              in_restart;
    logic [31:0]       in_smClkDiv;
    logic [31:0]       in_smExecCtrl;
    logic [ADDR_W-1:0] out_imemAddr;
    logic [15:0]       in_imemData;
    logic [15:0]       out_opCode;
    logic [4:0]        in_delay;
    logic              in_sideEnable;
    logic [4:0]        in_sideSet;
    logic              in_forceValid;
    logic [15:0]       in_forceOpcode;
    logic              out_execValid;
    logic              in_execStall;
    logic              in_jumpValid;
    logic [ADDR_W-1:0] in_jumpAddr;
    logic              out_sideSetValid;
    logic [4:0]        out_sideSet;
    logic              out_stalled;

    modport master (
        input  in_enable, in_restart, in_smClkDiv, in_smExecCtrl,
        input  in_imemData, in_delay, in_sideEnable, in_sideSet,
        input  in_forceValid, in_forceOpcode, in_execStall, in_jumpValid, in_jumpAddr,
        output out_imemAddr, out_opCode, out_execValid,
        output out_sideSetValid, out_sideSet, out_stalled
    );

    modport slave (
        output in_enable, in_restart, in_smClkDiv, in_smExecCtrl,
        output in_imemData, in_delay, in_sideEnable, in_sideSet,
        output in_forceValid, in_forceOpcode, in_execStall, in_jumpValid, in_jumpAddr,
        input  out_imemAddr, out_opCode, out_execValid,
        input  out_sideSetValid, out_sideSet, out_stalled
    );
endinterface

// File: rtl/pio_sm_sequencer.sv
// Instruction sequencer for one openPIO state machine: PC, clock-divider tick,
// stall/delay handling, program wrap, forced (EXEC) instructions and side-set.
module pio_sm_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DIV_W  = 16
) (
    input logic                in_clk,
    input logic                in_rst_n,
    pio_sm_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_DELAY
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DIV_W-1:0]  r_divCnt;
    logic [4:0]        r_delayCnt;
    logic              r_forcePending;
    logic [15:0]       r_forceOp;
    logic              r_sideSetValid;
    logic [4:0]        r_sideSet;
    logic              r_stalled;

    logic [DIV_W-1:0]  w_divLast;
    logic [ADDR_W-1:0] w_wrapTop;
    logic [ADDR_W-1:0] w_wrapBottom;
    logic              w_tick;
    logic              w_execValid;
    logic              w_accept;
    logic [ADDR_W-1:0] w_nextPc;
    logic              w_unusedBits;

    // A divider field of 0 wraps to all-ones here, which is exactly 65536-1.
    assign w_divLast    = bus.in_smClkDiv[31 -: DIV_W] - DIV_W'(1);
    assign w_wrapTop    = bus.in_smExecCtrl[12 +: ADDR_W];
    assign w_wrapBottom = bus.in_smExecCtrl[7 +: ADDR_W];
    assign w_unusedBits = &{1'b0, bus.in_smClkDiv[15:0], bus.in_smExecCtrl[31:17],
                            bus.in_smExecCtrl[6:0]};

    assign w_tick      = bus.in_enable & ~bus.in_restart & (r_divCnt == w_divLast);
    assign w_execValid = w_tick & (r_state != ST_DELAY);
    assign w_accept    = w_execValid & ~bus.in_execStall;

    assign bus.out_imemAddr     = r_pc;
    assign bus.out_opCode       = r_forcePending ? r_forceOp : bus.in_imemData;
    assign bus.out_execValid    = w_execValid;
    assign bus.out_sideSetValid = r_sideSetValid;
    assign bus.out_sideSet      = r_sideSet;
    assign bus.out_stalled      = r_stalled;

    // Jump beats wrap; a forced instruction leaves the program position alone.
    always_comb begin
        w_nextPc = r_pc + ADDR_W'(1);
        if (bus.in_jumpValid) begin
            w_nextPc = bus.in_jumpAddr;
        end else if (r_forcePending) begin
            w_nextPc = r_pc;
        end else if (r_pc == w_wrapTop) begin
            w_nextPc = w_wrapBottom;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_divCnt <= '0;
        end else if (bus.in_restart) begin
            r_divCnt <= '0;
        end else if (bus.in_enable) begin
            if (r_divCnt == w_divLast) begin
                r_divCnt <= '0;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state        <= ST_RUN;
            r_pc           <= '0;
            r_delayCnt     <= '0;
            r_forcePending <= 1'b0;
            r_forceOp      <= '0;
            r_sideSetValid <= 1'b0;
            r_sideSet      <= '0;
            r_stalled      <= 1'b0;
        end else begin
            r_sideSetValid <= 1'b0;
            if (bus.in_forceValid) begin
                r_forceOp <= bus.in_forceOpcode;
            end
            if (bus.in_restart) begin
                r_state        <= ST_RUN;
                r_delayCnt     <= '0;
                r_forcePending <= 1'b0;
                r_stalled      <= 1'b0;
            end else begin
                if (bus.in_forceValid) begin
                    r_forcePending <= 1'b1;
                end else if (w_accept && r_forcePending) begin
                    r_forcePending <= 1'b0;
                end
                // Only the first strobe of an instruction drives side-set; stall retries do not.
                if (w_execValid && bus.in_sideEnable && (r_state == ST_RUN)) begin
                    r_sideSetValid <= 1'b1;
                    r_sideSet      <= bus.in_sideSet;
                end
                if (w_tick) begin
                    case (r_state)
                        ST_RUN, ST_STALL: begin
                            if (bus.in_execStall) begin
                                r_state   <= ST_STALL;
                                r_stalled <= 1'b1;
                            end else begin
                                r_pc      <= w_nextPc;
                                r_stalled <= 1'b0;
                                if (bus.in_delay != 5'd0) begin
                                    r_state    <= ST_DELAY;
                                    r_delayCnt <= bus.in_delay;
                                end else begin
                                    r_state <= ST_RUN;
                                end
                            end
                        end
                        ST_DELAY: begin
                            if (r_delayCnt <= 5'd1) begin
                                r_state    <= ST_RUN;
                                r_delayCnt <= '0;
                            end else begin
                                r_delayCnt <= r_delayCnt - 5'd1;
                            end
                        end
                        default: r_state <= ST_RUN;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_sm_sequencer.sv
// Directed bench for pio_sm_sequencer: stand-in imem and decoder, hand-computed expectations
// for wrap, divider/delay timing, stall + side-set, force, jump, enable freeze, restart and reset.
module tb_pio_sm_sequencer;

    logic        clk;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] imem [32];

    pio_sm_sequencer_if #(.ADDR_W(5)) bus ();

    pio_sm_sequencer #(.ADDR_W(5), .DIV_W(16)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in decoder: delay in [12:8], side-set enable in [7], side-set value in [4:0].
    assign bus.in_imemData   = imem[bus.out_imemAddr];
    assign bus.in_delay      = bus.out_opCode[12:8];
    assign bus.in_sideEnable = bus.out_opCode[7];
    assign bus.in_sideSet    = bus.out_opCode[4:0];

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rst_n                = 1'b0;
        bus.in_enable        = 1'b0;
        bus.in_restart       = 1'b0;
        bus.in_smClkDiv      = 32'h0001_0000;
        bus.in_smExecCtrl    = 32'h0001_F000;
        bus.in_forceValid    = 1'b0;
        bus.in_forceOpcode   = 16'h0000;
        bus.in_execStall     = 1'b0;
        bus.in_jumpValid     = 1'b0;
        bus.in_jumpAddr      = 5'd0;
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        resetDut();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_addr", 16'(bus.out_imemAddr), 16'd0);
        checkOutput("rst_exec", 16'(bus.out_execValid), 16'd0);
        checkOutput("rst_ssv", 16'(bus.out_sideSetValid), 16'd0);
        checkOutput("rst_ss", 16'(bus.out_sideSet), 16'd0);
        checkOutput("rst_stalled", 16'(bus.out_stalled), 16'd0);

        $display("[TB] wrap with div=1");
        for (int i = 0; i < 4; i++) imem[i] = 16'h6000 | 16'(i);
        bus.in_smExecCtrl = (32'd3 << 12) | (32'd1 << 7);
        rst_n         = 1'b1;
        bus.in_enable = 1'b1;
        #1;
        begin
            logic [4:0] expPc [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1};
            for (int i = 0; i < 8; i++) begin
                checkOutput("wrap_pc", 16'(bus.out_imemAddr), 16'(expPc[i]));
                checkOutput("wrap_exec", 16'(bus.out_execValid), 16'd1);
                applyStimulus(1);
            end
        end

        $display("[TB] div=3 with delay 2");
        resetDut();
        imem[0]         = 16'h0200;
        imem[1]         = 16'h0001;
        bus.in_smClkDiv = 32'h0003_0000;
        bus.in_enable   = 1'b1;
        #1;
        for (int c = 1; c <= 13; c++) begin
            checkOutput("div_exec", 16'(bus.out_execValid), ((c == 3) || (c == 12)) ? 16'd1 : 16'd0);
            if (c == 4) checkOutput("div_pc", 16'(bus.out_imemAddr), 16'd1);
            applyStimulus(1);
        end

        $display("[TB] stall with side-set");
        resetDut();
        imem[0]          = 16'h008A;
        imem[1]          = 16'h0001;
        bus.in_enable    = 1'b1;
        bus.in_execStall = 1'b1;
        #1;
        checkOutput("stl_exec1", 16'(bus.out_execValid), 16'd1);
        checkOutput("stl_pc1", 16'(bus.out_imemAddr), 16'd0);
        applyStimulus(1);
        checkOutput("stl_stalled2", 16'(bus.out_stalled), 16'd1);
        checkOutput("stl_ssv2", 16'(bus.out_sideSetValid), 16'd1);
        checkOutput("stl_ss2", 16'(bus.out_sideSet), 16'h000A);
        checkOutput("stl_exec2", 16'(bus.out_execValid), 16'd1);
        checkOutput("stl_pc2", 16'(bus.out_imemAddr), 16'd0);
        applyStimulus(1);
        bus.in_execStall = 1'b0;
        #1;
        checkOutput("stl_stalled3", 16'(bus.out_stalled), 16'd1);
        checkOutput("stl_ssv3", 16'(bus.out_sideSetValid), 16'd0);
        checkOutput("stl_exec3", 16'(bus.out_execValid), 16'd1);
        checkOutput("stl_pc3", 16'(bus.out_imemAddr), 16'd0);
        applyStimulus(1);
        checkOutput("stl_stalled4", 16'(bus.out_stalled), 16'd0);
        checkOutput("stl_ssv4", 16'(bus.out_sideSetValid), 16'd0);
        checkOutput("stl_ss4", 16'(bus.out_sideSet), 16'h000A);
        checkOutput("stl_pc4", 16'(bus.out_imemAddr), 16'd1);

        $display("[TB] force during delay");
        resetDut();
        imem[0]       = 16'h0000;
        imem[1]       = 16'h0001;
        imem[2]       = 16'h0002;
        imem[3]       = 16'h0203;
        imem[4]       = 16'h0004;
        bus.in_enable = 1'b1;
        applyStimulus(3);
        checkOutput("frc_pc3", 16'(bus.out_imemAddr), 16'd3);
        checkOutput("frc_exec3", 16'(bus.out_execValid), 16'd1);
        applyStimulus(1);
        bus.in_forceValid  = 1'b1;
        bus.in_forceOpcode = 16'hE001;
        #1;
        checkOutput("frc_exec_d1", 16'(bus.out_execValid), 16'd0);
        checkOutput("frc_pc_d1", 16'(bus.out_imemAddr), 16'd4);
        applyStimulus(1);
        bus.in_forceValid = 1'b0;
        #1;
        checkOutput("frc_op_d2", bus.out_opCode, 16'hE001);
        checkOutput("frc_exec_d2", 16'(bus.out_execValid), 16'd0);
        applyStimulus(1);
        checkOutput("frc_exec_f", 16'(bus.out_execValid), 16'd1);
        checkOutput("frc_op_f", bus.out_opCode, 16'hE001);
        checkOutput("frc_pc_f", 16'(bus.out_imemAddr), 16'd4);
        applyStimulus(1);
        checkOutput("frc_exec_n", 16'(bus.out_execValid), 16'd1);
        checkOutput("frc_op_n", bus.out_opCode, 16'h0004);
        checkOutput("frc_pc_n", 16'(bus.out_imemAddr), 16'd4);

        $display("[TB] jump at wrap_top");
        resetDut();
        for (int i = 0; i < 4; i++) imem[i] = 16'(i);
        bus.in_smExecCtrl = (32'd3 << 12) | (32'd1 << 7);
        bus.in_enable     = 1'b1;
        applyStimulus(3);
        bus.in_jumpValid = 1'b1;
        bus.in_jumpAddr  = 5'd17;
        #1;
        checkOutput("jmp_pc3", 16'(bus.out_imemAddr), 16'd3);
        checkOutput("jmp_exec3", 16'(bus.out_execValid), 16'd1);
        applyStimulus(1);
        bus.in_jumpValid = 1'b0;
        #1;
        checkOutput("jmp_pc17", 16'(bus.out_imemAddr), 16'd17);

        $display("[TB] enable freeze, restart, async reset");
        resetDut();
        imem[0]       = 16'h0300;
        imem[1]       = 16'h0095;
        bus.in_enable = 1'b1;
        #1;
        checkOutput("frz_exec0", 16'(bus.out_execValid), 16'd1);
        applyStimulus(1);
        bus.in_enable = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("frz_exec", 16'(bus.out_execValid), 16'd0);
            checkOutput("frz_pc", 16'(bus.out_imemAddr), 16'd1);
            applyStimulus(1);
        end
        bus.in_enable  = 1'b1;
        bus.in_restart = 1'b1;
        #1;
        checkOutput("rs_exec_same", 16'(bus.out_execValid), 16'd0);
        applyStimulus(1);
        bus.in_restart = 1'b0;
        #1;
        checkOutput("rs_exec", 16'(bus.out_execValid), 16'd1);
        checkOutput("rs_pc", 16'(bus.out_imemAddr), 16'd1);
        checkOutput("rs_op", bus.out_opCode, 16'h0095);
        applyStimulus(1);
        checkOutput("rs_ssv", 16'(bus.out_sideSetValid), 16'd1);
        checkOutput("rs_ss", 16'(bus.out_sideSet), 16'h0015);
        checkOutput("rs_pc2", 16'(bus.out_imemAddr), 16'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_pc", 16'(bus.out_imemAddr), 16'd0);
        checkOutput("ar_ssv", 16'(bus.out_sideSetValid), 16'd0);
        checkOutput("ar_ss", 16'(bus.out_sideSet), 16'd0);
        checkOutput("ar_stalled", 16'(bus.out_stalled), 16'd0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
